// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : a2d_spi_resp
// Purpose  : ADC128S-style SPI responder standing in for the analog front end.
//            Every 16-bit frame captures a channel command on MOSI, and MISO
//            returns the conversion that the previous frame asked for.
//            The pins are asynchronous to clk and are synchronised internally.
// Ports    : clk        system clock (the only clock)
//            RST        synchronous, active-high reset
//            SS_n       SPI slave select, active low
//            SCLK       SPI clock, idle low (mode 0)
//            MOSI       command bits, MSB first
//            MISO       response bits, MSB first, 0 while deselected
//            BATT       battery level code (12 bits)
//            BRAKE      brake lever code (12 bits)
//            TORQUE     pedal torque code (12 bits)
//            xfer_done  1-clk pulse on a clean 16-bit frame
//            frm_err    1-clk pulse when SS_n rises with bit count != 16
//            last_ch    channel captured by the most recent clean frame
//            frm_cnt    clean-frame counter, wraps 255 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module a2d_spi_resp #(
  parameter logic [2:0]  BATT_CH   = 3'd0,
  parameter logic [2:0]  BRAKE_CH  = 3'd1,
  parameter logic [2:0]  TORQUE_CH = 3'd4,
  parameter logic [11:0] UNMAP_VAL = 12'hA5A
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] BATT,
  input  logic [11:0] BRAKE,
  input  logic [11:0] TORQUE,
  output logic        xfer_done,
  output logic        frm_err,
  output logic [2:0]  last_ch,
  output logic [7:0]  frm_cnt
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SHIFT  = 2'd1;
  localparam logic [1:0] c_ST_FINISH = 2'd2;

  localparam logic [4:0] c_FRAME_BITS = 5'd16;
  localparam logic [4:0] c_CNT_SAT    = 5'd17;

  // [0] first sync flop, [1] second sync flop, [2] edge-detect history
  logic [2:0]  r_ss_sync;
  logic [2:0]  r_sclk_sync;
  logic [1:0]  r_mosi_sync;

  logic [1:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_tx_shft;
  // Only command bits [13:11] are ever consumed; 14 bits of history is
  // enough to hold them in place after 16 shifts.
  logic [13:0] r_rx_shft;
  logic [2:0]  r_ptr_ch;
  logic [2:0]  r_last_ch;
  logic [7:0]  r_frm_cnt;
  logic        r_xfer_done;
  logic        r_frm_err;

  // After reset the preset SS_n pipeline must refill with the real pin level
  // before a falling edge is trusted; otherwise a reset taken mid-frame would
  // see a fake SS_n fall and start serving the remainder of that frame.
  logic [1:0]  r_settle;
  logic        r_armed;

  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic [11:0] w_val;

  assign w_ss_fall   = ~r_ss_sync[1] &  r_ss_sync[2];
  assign w_ss_rise   =  r_ss_sync[1] & ~r_ss_sync[2];
  assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];

  // Priority order resolves colliding channel parameters.
  always_comb begin
    w_val = UNMAP_VAL;
    if (r_ptr_ch == BATT_CH)
      w_val = BATT;
    else if (r_ptr_ch == BRAKE_CH)
      w_val = BRAKE;
    else if (r_ptr_ch == TORQUE_CH)
      w_val = TORQUE;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_ss_sync   <= 3'b111;
      r_sclk_sync <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_settle    <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      if (r_settle != 2'd3)
        r_settle <= r_settle + 2'd1;
      if ((r_settle == 2'd3) && r_ss_sync[1])
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= c_ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_tx_shft   <= 16'h0000;
      r_rx_shft   <= 14'h0000;
      r_ptr_ch    <= 3'd0;
      r_last_ch   <= 3'd0;
      r_frm_cnt   <= 8'd0;
      r_xfer_done <= 1'b0;
      r_frm_err   <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      r_frm_err   <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_ss_fall && r_armed) begin
            r_tx_shft <= {4'h0, w_val};
            r_bit_cnt <= 5'd0;
            r_state   <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          // SS_n rise takes precedence over any SCLK edge in the same clk.
          if (w_ss_rise) begin
            if (r_bit_cnt == c_FRAME_BITS) begin
              r_state <= c_ST_FINISH;
            end else begin
              r_frm_err <= 1'b1;
              r_state   <= c_ST_IDLE;
            end
          end else if (w_sclk_rise) begin
            r_rx_shft <= {r_rx_shft[12:0], r_mosi_sync[1]};
            if (r_bit_cnt != c_CNT_SAT)
              r_bit_cnt <= r_bit_cnt + 5'd1;
          end else if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
            // A fall before any rise (SCLK high at select) keeps the MSB.
            r_tx_shft <= {r_tx_shft[14:0], 1'b0};
          end
        end
        c_ST_FINISH: begin
          r_ptr_ch    <= r_rx_shft[13:11];
          r_last_ch   <= r_rx_shft[13:11];
          r_xfer_done <= 1'b1;
          r_frm_cnt   <= r_frm_cnt + 8'd1;
          r_state     <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign MISO      = ~r_ss_sync[1] & r_tx_shft[15];
  assign xfer_done = r_xfer_done;
  assign frm_err   = r_frm_err;
  assign last_ch   = r_last_ch;
  assign frm_cnt   = r_frm_cnt;

endmodule
`default_nettype wire
